// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: mask encodings, FSM states,
// the latched request, and byte-lane steering/extraction functions.
package dmem_pkg;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [2:0]  mask;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    function automatic logic access_illegal(input logic [2:0] mask, input logic [1:0] lo);
        case (mask)
            MASK_B, MASK_BU: return 1'b0;
            MASK_H, MASK_HU: return lo[0];
            MASK_W:          return lo != 2'b00;
            default:         return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] mask, input logic [1:0] lo);
        case (mask[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data; the byte enables pick the lanes.
    function automatic logic [31:0] store_align(input logic [31:0] data, input logic [2:0] mask);
        case (mask[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] mask,
                                                 input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (mask)
            MASK_B:  return {{24{b[7]}}, b};
            MASK_BU: return {24'h0, b};
            MASK_H:  return {{16{h[15]}}, h};
            MASK_HU: return {16'h0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage to data-memory bus; master is the pipeline, slave is the responder.
interface dmem_responder_if;
    logic        mem_rd_M;
    logic        mem_wr_M;
    logic [2:0]  mem_mask_M;
    logic [31:0] alu_o_M;
    logic [31:0] wr_data_M;
    logic [31:0] rd_data_M;
    logic        mem_stall;
    logic        mem_misalign;

    modport master (
        output mem_rd_M, mem_wr_M, mem_mask_M, alu_o_M, wr_data_M,
        input  rd_data_M, mem_stall, mem_misalign
    );

    modport slave (
        input  mem_rd_M, mem_wr_M, mem_mask_M, alu_o_M, wr_data_M,
        output rd_data_M, mem_stall, mem_misalign
    );
endinterface

// File: rtl/dmem_sram.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, byte write enables, registered read.
// Read data appears the cycle after an enabled non-write access; contents are never reset.
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: legal access stalls WAIT_CYCLES+1 cycles, result in DONE.
// Illegal access pulses mem_misalign without stalling; requests sampled only in IDLE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    logic [3:0]  cnt;
    req_t        req_q;

    logic        req_vld;
    logic        illegal;
    logic        accept;
    logic        rd_issue;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        unused_addr_hi;

    assign req_vld = bus.mem_rd_M | bus.mem_wr_M;
    assign illegal = access_illegal(bus.mem_mask_M, bus.alu_o_M[1:0]);
    assign accept  = (state == IDLE) && req_vld && !illegal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            req_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q <= '{wr:   bus.mem_wr_M,
                                   mask: bus.mem_mask_M,
                                   addr: bus.alu_o_M,
                                   data: bus.wr_data_M};
                        cnt   <= 4'(WAIT_CYCLES);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Load reads on the edge into DONE; store commits on the edge out of DONE
    // only if reset is not being applied on that same edge.
    assign rd_issue  = (state == BUSY) && (cnt == 4'd1) && !req_q.wr;
    assign ram_we    = ((state == DONE) && req_q.wr && rst)
                       ? byte_enable(req_q.mask, req_q.addr[1:0]) : 4'b0000;
    assign ram_en    = rd_issue | (|ram_we);
    assign ram_wdata = store_align(req_q.data, req_q.mask);

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (req_q.addr[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.mem_stall    = accept || (state == BUSY);
    assign bus.mem_misalign = (state == IDLE) && req_vld && illegal;
    assign bus.rd_data_M    = ((state == DONE) && !req_q.wr)
                              ? load_extract(ram_rdata, req_q.mask, req_q.addr[1:0]) : 32'h0;

    assign unused_addr_hi = ^req_q.addr[31:AW+2];

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (WAIT_CYCLES 1 and 4) against a byte-array model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus1 ();
    dmem_responder_if bus4 ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int          sel = 0;
    logic        rd_d = 1'b0, wr_d = 1'b0;
    logic [2:0]  mask_d = 3'b0;
    logic [31:0] addr_d = 32'h0, data_d = 32'h0;

    assign bus1.mem_rd_M   = (sel == 0) & rd_d;
    assign bus1.mem_wr_M   = (sel == 0) & wr_d;
    assign bus1.mem_mask_M = mask_d;
    assign bus1.alu_o_M    = addr_d;
    assign bus1.wr_data_M  = data_d;
    assign bus4.mem_rd_M   = (sel != 0) & rd_d;
    assign bus4.mem_wr_M   = (sel != 0) & wr_d;
    assign bus4.mem_mask_M = mask_d;
    assign bus4.alu_o_M    = addr_d;
    assign bus4.wr_data_M  = data_d;

    logic        stall_s, mis_s;
    logic [31:0] rd_s;
    assign stall_s = (sel != 0) ? bus4.mem_stall    : bus1.mem_stall;
    assign mis_s   = (sel != 0) ? bus4.mem_misalign : bus1.mem_misalign;
    assign rd_s    = (sel != 0) ? bus4.rd_data_M    : bus1.rd_data_M;

    int n_tests = 0;
    int n_fail  = 0;

    // Byte-addressed reference memory per instance (1024 words = 4096 bytes).
    logic [7:0] mdl [2][4096];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_illegal(input logic [2:0] mask, input logic [31:0] addr);
        int size;
        if (mask == 3'd3 || mask > 3'd5) return 1'b1;
        size = 1 << mask[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] mdl_load(input int d, input logic [2:0] mask, input logic [31:0] addr);
        int n;
        int a;
        logic [31:0] v;
        n = 1 << mask[1:0];
        a = int'(addr % 4096);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[d][a+i];
        if (!mask[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!mask[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic mdl_store(input int d, input logic [2:0] mask, input logic [31:0] addr, input logic [31:0] data);
        int n;
        int a;
        n = 1 << mask[1:0];
        a = int'(addr % 4096);
        for (int i = 0; i < n; i++) mdl[d][a+i] = data[8*i +: 8];
    endtask

    task automatic idle_inputs();
        rd_d = 1'b0;
        wr_d = 1'b0;
    endtask

    // Called just after a rising edge with the selected DUT in IDLE; returns the
    // same way, so consecutive calls are back-to-back requests.
    task automatic access(input logic wr, input logic rd, input logic [2:0] mask, input logic [31:0] addr,
                          input logic [31:0] data, input string tag, output logic [31:0] got);
        int          w;
        int          stalls;
        bit          rd_nz;
        bit          ill;
        logic [31:0] expv;
        w      = (sel != 0) ? 4 : 1;
        stalls = 0;
        rd_nz  = 1'b0;
        ill    = exp_illegal(mask, addr);
        expv   = wr ? 32'h0 : mdl_load(sel, mask, addr);
        wr_d = wr; rd_d = rd; mask_d = mask; addr_d = addr; data_d = data;
        @(negedge clk);
        chk({tag, ".misalign"}, 32'(mis_s), 32'(ill));
        if (ill) begin
            chk({tag, ".stall"}, 32'(stall_s), 32'h0);
            chk({tag, ".rd_zero"}, rd_s, 32'h0);
            got = rd_s;
        end else begin
            while (stall_s && stalls < 40) begin
                stalls++;
                if (rd_s != 32'h0) rd_nz = 1'b1;
                @(negedge clk);
            end
            chk({tag, ".stall_cycles"}, 32'(stalls), 32'(w + 1));
            chk({tag, ".rd_zero_in_stall"}, 32'(rd_nz), 32'h0);
            got = rd_s;
            chk({tag, ".rd_data"}, rd_s, expv);
            if (wr) mdl_store(sel, mask, addr, data);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic prefill(input int words);
        logic [31:0] g;
        for (int k = 0; k < words; k++) access(1'b1, 1'b0, 3'b010, 32'(4 * k), $urandom, "prefill", g);
    endtask

    task automatic random_phase(input int count, input int lim);
        logic [2:0]  m;
        logic [31:0] a;
        logic        w;
        logic        r;
        logic [31:0] g;
        for (int i = 0; i < count; i++) begin
            m = 3'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, lim));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << m[1:0]) - 32'd1);
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            access(w, r, m, a, $urandom, "rnd", g);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] g;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.stall1", 32'(bus1.mem_stall), 32'h0);
        chk("rst.mis1",   32'(bus1.mem_misalign), 32'h0);
        chk("rst.rd1",    bus1.rd_data_M, 32'h0);
        chk("rst.stall4", 32'(bus4.mem_stall), 32'h0);
        chk("rst.rd4",    bus4.rd_data_M, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        sel = 0;
        prefill(256);
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, "sw100", g);
        access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, "lw100", g);
        chk("lw100.value", g, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h1234_5680, "sb103", g);
        access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, "lb103", g);
        chk("lb103.value", g, 32'hFFFF_FF80);
        access(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, "lbu103", g);
        chk("lbu103.value", g, 32'h0000_0080);
        access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, "lw100b", g);
        chk("lw100b.value", g, 32'h80AD_BEEF);
        access(1'b1, 1'b0, 3'b001, 32'h202, 32'hABCD_8001, "sh202", g);
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0, "lh202", g);
        chk("lh202.value", g, 32'hFFFF_8001);
        access(1'b0, 1'b1, 3'b101, 32'h202, 32'h0, "lhu202", g);
        chk("lhu202.value", g, 32'h0000_8001);
        access(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, "lw101", g);
        access(1'b1, 1'b0, 3'b001, 32'h203, 32'h0000_FFFF, "sh203", g);
        access(1'b1, 1'b0, 3'b011, 32'h200, 32'hFFFF_FFFF, "mask3", g);
        access(1'b1, 1'b0, 3'b110, 32'h200, 32'hFFFF_FFFF, "mask6", g);
        access(1'b0, 1'b1, 3'b111, 32'h200, 32'h0, "mask7", g);
        access(1'b0, 1'b1, 3'b010, 32'h200, 32'h0, "lw200", g);
        access(1'b1, 1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, "rdwr204", g);
        access(1'b0, 1'b1, 3'b010, 32'h204, 32'h0, "lw204", g);
        chk("lw204.value", g, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 3'b010, 32'h1000_0308, 32'h5A5A_A5A5, "swwrap", g);
        access(1'b0, 1'b1, 3'b010, 32'h0000_0308, 32'h0, "lwwrap", g);
        chk("lwwrap.value", g, 32'h5A5A_A5A5);

        // Reset while the store is in BUSY: it must never commit.
        wr_d = 1'b1; rd_d = 1'b0; mask_d = 3'b010; addr_d = 32'h300; data_d = 32'h1234_5678;
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstbusy.stall", 32'(stall_s), 32'h0);
        chk("rstbusy.rd",    rd_s, 32'h0);
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, "lw300", g);

        // Reset while the store sits in DONE: the commit edge is aborted.
        wr_d = 1'b1; rd_d = 1'b0; mask_d = 3'b010; addr_d = 32'h304; data_d = 32'h8765_4321;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b1;
        access(1'b0, 1'b1, 3'b010, 32'h304, 32'h0, "lw304", g);

        random_phase(120, 1023);

        sel = 1;
        prefill(32);
        for (int k = 0; k < 6; k++) access(1'b0, 1'b1, 3'b010, 32'(4 * k), 32'h0, "b2b_lw", g);
        random_phase(120, 127);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
